// File: rtl/ifm_col_feeder.sv
// Column feeder for three 3-tap IFM shift registers forming a 3x3 window.
// Optional 1-pixel zero border ("same" convolution) via `define IFM_ZERO_PAD_EN.
module ifm_col_feeder #(
  parameter int IFM_W     = 8,
  parameter int IFM_H     = 8,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic              busy,
  output logic              done,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_rd_data,
  output logic [7:0]        ifm_in0,
  output logic [7:0]        ifm_in1,
  output logic [7:0]        ifm_in2,
  output logic              ifm_read,
  output logic              win_valid,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col
);

`ifdef IFM_ZERO_PAD_EN
  localparam int STRIPES = IFM_H;
  localparam int COLS    = IFM_W + 2;
`else
  localparam int STRIPES = IFM_H - 2;
  localparam int COLS    = IFM_W;
`endif

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WT   = 3'd2;
  localparam logic [2:0] S_PUSH = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_reg;
  logic [15:0]       row_reg;
  logic [15:0]       col_reg;
  logic [1:0]        k_reg;
  logic [7:0]        ifm0_reg;
  logic [7:0]        ifm1_reg;
  logic [7:0]        ifm2_reg;
  logic              win_valid_reg;
  logic [7:0]        win_row_reg;
  logic [7:0]        win_col_reg;

  logic [31:0]       pix_row;
  logic [31:0]       pix_col;
  logic              pix_in_plane;
  logic [ADDR_W-1:0] addr_calc;
  logic [7:0]        cap_data;
  logic              last_col;
  logic              last_row;

`ifdef IFM_ZERO_PAD_EN
  // Remembers whether the previous RD cycle was a border pixel, so the
  // returned (stale) SRAM word is replaced by zero at capture time.
  logic              pad_d_reg;
`endif

  always_comb begin
    pix_row = 32'(row_reg) + 32'(k_reg);
    pix_col = 32'(col_reg);
`ifdef IFM_ZERO_PAD_EN
    pix_in_plane = (pix_row >= 32'd1) && (pix_row <= 32'(IFM_H)) &&
                   (pix_col >= 32'd1) && (pix_col <= 32'(IFM_W));
    addr_calc    = ADDR_W'(BASE_ADDR) + ADDR_W'((pix_row - 32'd1) * 32'(IFM_W))
                 + ADDR_W'(pix_col - 32'd1);
    cap_data     = pad_d_reg ? 8'd0 : sram_rd_data;
`else
    pix_in_plane = 1'b1;
    addr_calc    = ADDR_W'(BASE_ADDR) + ADDR_W'(pix_row * 32'(IFM_W)) + ADDR_W'(pix_col);
    cap_data     = sram_rd_data;
`endif
    last_col = (col_reg == 16'(COLS - 1));
    last_row = (row_reg == 16'(STRIPES - 1));
  end

  assign busy       = (state_reg == S_RD) || (state_reg == S_WT) || (state_reg == S_PUSH);
  assign done       = (state_reg == S_DONE);
  assign sram_rd_en = (state_reg == S_RD) && pix_in_plane;
  assign sram_addr  = sram_rd_en ? addr_calc : '0;
  assign ifm_read   = (state_reg == S_PUSH) && en;
  assign ifm_in0    = ifm0_reg;
  assign ifm_in1    = ifm1_reg;
  assign ifm_in2    = ifm2_reg;
  assign win_valid  = win_valid_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      k_reg         <= '0;
      ifm0_reg      <= '0;
      ifm1_reg      <= '0;
      ifm2_reg      <= '0;
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
`ifdef IFM_ZERO_PAD_EN
      pad_d_reg     <= 1'b0;
`endif
    end else begin
      win_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RD;
            row_reg   <= '0;
            col_reg   <= '0;
            k_reg     <= '0;
          end
        end
        S_RD: begin
`ifdef IFM_ZERO_PAD_EN
          pad_d_reg <= !pix_in_plane;
`endif
          // Data lands one cycle after its read, so row k-1 is captured now.
          if (k_reg == 2'd1) ifm0_reg <= cap_data;
          if (k_reg == 2'd2) ifm1_reg <= cap_data;
          if (k_reg == 2'd2) begin
            k_reg     <= '0;
            state_reg <= S_WT;
          end else begin
            k_reg <= k_reg + 2'd1;
          end
        end
        S_WT: begin
          ifm2_reg  <= cap_data;
          state_reg <= S_PUSH;
        end
        S_PUSH: begin
          if (en) begin
            if (col_reg >= 16'd2) begin
              win_valid_reg <= 1'b1;
              win_row_reg   <= row_reg[7:0];
              win_col_reg   <= 8'(col_reg - 16'd2);
            end
            if (last_col) begin
              col_reg   <= '0;
              row_reg   <= row_reg + 16'd1;
              state_reg <= last_row ? S_DONE : S_RD;
            end else begin
              col_reg   <= col_reg + 16'd1;
              state_reg <= S_RD;
            end
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
